uart2wifi_cmd_bridge: RTL

- Upstream command decoder for the register file (uart2wifi_core_sram); sits between the UART byte receiver/transmitter and the register bus.
- Consumes host byte frames, issues single-cycle write/read strobes on the register bus, and returns acknowledge or read-data bytes to the UART transmitter.
- Port signals map one-to-one onto reg_if fields: reg_addr, reg_wdata, reg_write, reg_read, reg_rdata.

---
 rtl/uart2wifi_pkg.sv | 23 ++
 rtl/uart2wifi_cmd_bridge_if.sv | 47 ++++
 rtl/uart2wifi_tx_buf.sv | 57 +++++
 rtl/uart2wifi_cmd_bridge.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart2wifi_pkg.sv
// Shared definitions for the UART-to-register-bus command bridge.
// Holds the frame/response byte codes, the bridge FSM state type and
// the fixed number of data bytes carried per register access.
package uart2wifi_pkg;

    localparam int DATA_BYTES = 4;

    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        BUS_WR   = 3'd3,
        BUS_RD   = 3'd4,
        RD_CAP   = 3'd5,
        SEND     = 3'd6
    } cmd_state_t;

endpackage

// File: rtl/uart2wifi_cmd_bridge_if.sv
// Signal bundle between the command bridge and its surroundings
// (UART receiver, UART transmitter, register file).
//
// Handshakes:
//   rx: the receiver pulses rx_valid for one cycle per byte; the byte is
//       taken only when rx_ready is 1 in that cycle, otherwise it is lost.
//   tx: tx_valid/tx_data are held until the cycle where tx_valid &&
//       tx_ready; that cycle transfers the byte. tx_data never changes
//       while tx_valid && !tx_ready.
//   reg: reg_write / reg_read are one-cycle strobes; reg_rdata is valid
//        the cycle after reg_read.
//
// Modports: slave = bridge side, master = environment side.
// state_dbg exposes the bridge FSM state for observation.
interface uart2wifi_cmd_bridge_if
    import uart2wifi_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [DATA_W-1:0] reg_rdata;
    logic              err_pulse;
    cmd_state_t        state_dbg;

    modport slave (
        input  rx_valid, rx_data, tx_ready, reg_rdata,
        output rx_ready, tx_valid, tx_data, reg_addr, reg_wdata,
               reg_write, reg_read, err_pulse, state_dbg
    );

    modport master (
        output rx_valid, rx_data, tx_ready, reg_rdata,
        input  rx_ready, tx_valid, tx_data, reg_addr, reg_wdata,
               reg_write, reg_read, err_pulse, state_dbg
    );

endinterface

// File: rtl/uart2wifi_tx_buf.sv
// Response buffer: loads up to DATA_BYTES bytes at once and presents them
// LSB first on a valid/ready output.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load_i          load load_data_i / load_cnt_i (used only while empty)
//   load_data_i     bytes to send, byte 0 in bits [7:0]
//   load_cnt_i      number of bytes to send (1..DATA_BYTES)
//   tx_valid_o      a byte is pending
//   tx_data_o       pending byte
//   tx_ready_i      consumer accepts byte when tx_valid_o && tx_ready_i
//   last_o          the final pending byte is transferred this cycle
module uart2wifi_tx_buf
    import uart2wifi_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [DATA_BYTES*8-1:0] load_data_i,
    input  logic [2:0]              load_cnt_i,
    output logic                    tx_valid_o,
    output logic [7:0]              tx_data_o,
    input  logic                    tx_ready_i,
    output logic                    last_o
);
    logic [DATA_BYTES*8-1:0] data_q, data_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    fire;

    assign tx_valid_o = (cnt_q != 3'd0);
    assign tx_data_o  = data_q[7:0];
    assign fire       = tx_valid_o && tx_ready_i;
    assign last_o     = fire && (cnt_q == 3'd1);

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = load_cnt_i;
        end else if (fire) begin
            // Shift the next byte into the output slot; drained bytes become 0.
            data_d = {8'h00, data_q[DATA_BYTES*8-1:8]};
            cnt_d  = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= 3'd0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/uart2wifi_cmd_bridge.sv
// Command bridge: decodes host byte frames from the UART receiver into
// single-cycle register-bus strobes and returns 'K', 'E' or 4 read-data
// bytes (LSB first) to the UART transmitter.
//   write frame: 'W' addr d0 d1 d2 d3   -> 'K'
//   read frame:  'R' addr               -> rdata[7:0] .. rdata[31:24]
//   bad command / bad address           -> 'E' + err_pulse
//   inter-byte silence of TIMEOUT_CYCLES inside a frame -> abort + err_pulse
//   byte arriving while not ready       -> dropped + err_pulse
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   uart2wifi_cmd_bridge_if.slave (rx, tx, register bus, err, state)
module uart2wifi_cmd_bridge
    import uart2wifi_pkg::*;
#(
    parameter int NUM_REGS       = 3,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 100000
)(
    input  logic                    clk,
    input  logic                    rst,
    uart2wifi_cmd_bridge_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    cmd_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic              is_wr_q, is_wr_d;
    logic [TW-1:0]     idle_q, idle_d;

    logic              accept;
    logic              cmd_ok;
    logic              addr_ok;
    logic              in_frame;
    logic              timeout;

    logic              buf_load;
    logic [DATA_W-1:0] buf_data;
    logic [2:0]        buf_cnt;
    logic              buf_last;
    logic              rx_ready;

    assign accept   = bus.rx_valid && rx_ready;
    assign cmd_ok   = (bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD);
    assign addr_ok  = (bus.rx_data < 8'(NUM_REGS));
    assign in_frame = (state_q == GET_ADDR) || (state_q == GET_DATA);
    // An accepted byte in the limit cycle wins over the timeout.
    assign timeout  = in_frame && !accept && (idle_q == TW'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            bcnt_q  <= 2'd0;
            is_wr_q <= 1'b0;
            idle_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bcnt_q  <= bcnt_d;
            is_wr_q <= is_wr_d;
            idle_q  <= idle_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bcnt_d  = bcnt_q;
        is_wr_d = is_wr_q;
        idle_d  = (in_frame && !accept && !timeout) ? idle_q + TW'(1) : '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_ok) begin
                        is_wr_d = (bus.rx_data == CMD_WR);
                        state_d = GET_ADDR;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (accept) begin
                    if (!addr_ok) begin
                        state_d = SEND;
                    end else begin
                        addr_d = ADDR_W'(bus.rx_data);
                        if (is_wr_q) begin
                            bcnt_d  = 2'd0;
                            state_d = GET_DATA;
                        end else begin
                            state_d = BUS_RD;
                        end
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (accept) begin
                    // Little-endian: each new byte enters at the top.
                    wdata_d = {bus.rx_data, wdata_q[DATA_W-1:8]};
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = BUS_WR;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            BUS_WR:  state_d = SEND;
            BUS_RD:  state_d = RD_CAP;
            RD_CAP:  state_d = SEND;
            SEND: begin
                if (buf_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        rx_ready      = (state_q == IDLE) || in_frame;
        bus.reg_write = (state_q == BUS_WR);
        bus.reg_read  = (state_q == BUS_RD);
        buf_load      = 1'b0;
        buf_data      = '0;
        buf_cnt       = 3'd0;
        bus.err_pulse = bus.rx_valid && !rx_ready;
        case (state_q)
            IDLE: begin
                if (accept && !cmd_ok) begin
                    buf_load      = 1'b1;
                    buf_data      = {24'h0, RSP_ERR};
                    buf_cnt       = 3'd1;
                    bus.err_pulse = 1'b1;
                end
            end
            GET_ADDR: begin
                if (accept && !addr_ok) begin
                    buf_load      = 1'b1;
                    buf_data      = {24'h0, RSP_ERR};
                    buf_cnt       = 3'd1;
                    bus.err_pulse = 1'b1;
                end else if (timeout) begin
                    bus.err_pulse = 1'b1;
                end
            end
            GET_DATA: begin
                if (timeout) begin
                    bus.err_pulse = 1'b1;
                end
            end
            BUS_WR: begin
                buf_load = 1'b1;
                buf_data = {24'h0, RSP_ACK};
                buf_cnt  = 3'd1;
            end
            RD_CAP: begin
                buf_load = 1'b1;
                buf_data = bus.reg_rdata;
                buf_cnt  = 3'(DATA_BYTES);
            end
            default: ;
        endcase
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.state_dbg = state_q;

    uart2wifi_tx_buf u_tx_buf (
        .clk         (clk),
        .rst_n       (rst),
        .load_i      (buf_load),
        .load_data_i (buf_data),
        .load_cnt_i  (buf_cnt),
        .tx_valid_o  (bus.tx_valid),
        .tx_data_o   (bus.tx_data),
        .tx_ready_i  (bus.tx_ready),
        .last_o      (buf_last)
    );

endmodule
